// File: rtl/dino_pkg.sv
// Shared types and constants for the dino motion controller.
// Contents: state enum, sprite codes, default horizon Y, velocity width and
// a helper mapping (state, animation phase) onto a sprite code.
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DUCK,
    AIR,
    DEAD
  } state_e;

  localparam logic [3:0] SPR_RUN_A  = 4'd0;
  localparam logic [3:0] SPR_RUN_B  = 4'd1;
  localparam logic [3:0] SPR_DUCK_A = 4'd2;
  localparam logic [3:0] SPR_DUCK_B = 4'd3;
  localparam logic [3:0] SPR_JUMP   = 4'd4;
  localparam logic [3:0] SPR_DEAD   = 4'd5;
  localparam logic [3:0] SPR_IDLE   = 4'd6;

  localparam int GROUND_Y_DEF = 360;
  localparam int VEL_W        = 8;

  function automatic logic [3:0] sprite_for(input state_e s, input logic ph);
    logic [3:0] spr;
    case (s)
      RUN:     spr = ph ? SPR_RUN_B : SPR_RUN_A;
      DUCK:    spr = ph ? SPR_DUCK_B : SPR_DUCK_A;
      AIR:     spr = SPR_JUMP;
      DEAD:    spr = SPR_DEAD;
      default: spr = SPR_IDLE;
    endcase
    return spr;
  endfunction

endpackage

// File: rtl/dino_vert_integrator.sv
// Vertical motion datapath: velocity/Y integration, top-of-screen clamp, landing detect.
// Latency: y_o is registered, updated on the tick the controls are sampled.
// Backpressure: none; integrates once per AnimateClk tick when told to.
// Ports: AnimateClk/rst (async, active-high); launch_i starts a jump from the
// current Y this tick; fly_i integrates one airborne step; freeze_i holds Y and
// velocity (highest priority); fast_drop_i triples gravity; with none of these
// asserted the dino is parked on the ground. y_o is the dino top-left Y;
// landed_o flags that the next flight step reaches the ground.
module dino_vert_integrator import dino_pkg::*; #(
  parameter int Y_W      = 11,
  parameter int GROUND_Y = GROUND_Y_DEF,
  parameter int JUMP_V0  = 20,
  parameter int GRAVITY  = 1
) (
  input  logic           AnimateClk,
  input  logic           rst,
  input  logic           launch_i,
  input  logic           fly_i,
  input  logic           freeze_i,
  input  logic           fast_drop_i,
  output logic [Y_W-1:0] y_o,
  output logic           landed_o
);

  localparam logic signed [VEL_W-1:0] V0_S     = VEL_W'(JUMP_V0);
  localparam logic signed [VEL_W-1:0] G_S      = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] G3_S     = VEL_W'(3 * GRAVITY);
  localparam logic signed [Y_W:0]     GROUND_S = (Y_W+1)'(GROUND_Y);
  localparam logic [Y_W-1:0]          GROUND_U = Y_W'(GROUND_Y);

  logic [Y_W-1:0]          y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic signed [VEL_W-1:0] v_base, vel_sum;
  logic signed [Y_W:0]     y_ext, v_ext, vq_ext, y_sum, y_fly;

  always_comb begin
    // A launch applies the take-off speed in the same tick, so the first
    // airborne frame is already GROUND_Y - JUMP_V0.
    v_base  = launch_i ? -V0_S : vel_q;
    vel_sum = v_base + (fast_drop_i ? G3_S : G_S);
    y_ext   = $signed({1'b0, y_q});
    v_ext   = $signed({{(Y_W+1-VEL_W){v_base[VEL_W-1]}}, v_base});
    vq_ext  = $signed({{(Y_W+1-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    y_sum   = y_ext + v_ext;
    // Landing is judged on the pure flight step (no launch mux) so the
    // controller can use it to pick its next state without a loop.
    y_fly    = y_ext + vq_ext;
    landed_o = (y_fly >= GROUND_S);

    y_d   = y_q;
    vel_d = vel_q;
    if (freeze_i) begin
      y_d   = y_q;
      vel_d = vel_q;
    end else if (launch_i || fly_i) begin
      if (fly_i && landed_o) begin
        y_d   = GROUND_U;
        vel_d = '0;
      end else if (y_sum[Y_W]) begin
        // Above the top edge: pin Y but keep velocity integrating.
        y_d   = '0;
        vel_d = vel_sum;
      end else begin
        y_d   = y_sum[Y_W-1:0];
        vel_d = vel_sum;
      end
    end else begin
      y_d   = GROUND_U;
      vel_d = '0;
    end
  end

  always_ff @(posedge AnimateClk or posedge rst) begin
    if (rst) begin
      y_q   <= GROUND_U;
      vel_q <= '0;
    end else begin
      y_q   <= y_d;
      vel_q <= vel_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame T-Rex motion/state controller feeding the dino sprite drawer.
// Latency: inputs sampled on tick N appear on the registered outputs after tick N.
// Backpressure: none; advances exactly once per AnimateClk tick.
// Ports: AnimateClk, rst (async, active-high); jump (level, edge-detected),
// duck (level), hit (collision level); dino_y top-left Y, sprite_sel sprite
// code, airborne/on_ground/ducking/dead status flags.
// Build option: define DINO_FAST_DROP_EN to triple gravity while duck is held in AIR.
module dino_motion_ctrl import dino_pkg::*; #(
  parameter int GROUND_Y        = GROUND_Y_DEF,
  parameter int JUMP_V0         = 20,
  parameter int GRAVITY         = 1,
  parameter int RUN_FRAME_TICKS = 6,
  parameter int Y_W             = 11
) (
  input  logic           AnimateClk,
  input  logic           rst,
  input  logic           jump,
  input  logic           duck,
  input  logic           hit,
  output logic [Y_W-1:0] dino_y,
  output logic [3:0]     sprite_sel,
  output logic           airborne,
  output logic           on_ground,
  output logic           ducking,
  output logic           dead
);

  localparam int CNT_W = (RUN_FRAME_TICKS > 1) ? $clog2(RUN_FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_FRAME_TICKS - 1);

  state_e           state_q, state_d;
  logic             jump_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;
  logic [3:0]       sprite_sel_q;
  logic             airborne_q, on_ground_q, ducking_q, dead_q;

  logic jump_rise, launch, fly, freeze, fast_drop, landed, stay_anim;

`ifdef DINO_FAST_DROP_EN
  assign fast_drop = (state_q == AIR) && duck;
`else
  assign fast_drop = 1'b0;
`endif

  always_comb begin
    jump_rise = jump & ~jump_q;

    state_d = state_q;
    case (state_q)
      IDLE: if (jump_rise) state_d = AIR;
      RUN: begin
        if (hit)            state_d = DEAD;
        else if (jump_rise) state_d = AIR;
        else if (duck)      state_d = DUCK;
      end
      DUCK: begin
        if (hit)            state_d = DEAD;
        else if (jump_rise) state_d = AIR;
        else if (!duck)     state_d = RUN;
      end
      AIR: begin
        if (hit)         state_d = DEAD;
        else if (landed) state_d = duck ? DUCK : RUN;
      end
      DEAD: if (jump_rise) state_d = RUN;
      default: state_d = IDLE;
    endcase

    launch = (state_d == AIR) && (state_q != AIR);
    fly    = (state_q == AIR) && !hit;
    // Covers both a hit in flight and sitting dead; a respawn leaves DEAD
    // with freeze low, which parks the integrator back on the ground.
    freeze = (state_d == DEAD);

    // Leg animation only runs while remaining in RUN or DUCK; any entry
    // (including RUN<->DUCK) restarts it from phase A.
    stay_anim   = ((state_d == RUN) || (state_d == DUCK)) && (state_d == state_q);
    frame_cnt_d = '0;
    phase_d     = 1'b0;
    if (stay_anim) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge AnimateClk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      jump_q       <= 1'b0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      sprite_sel_q <= SPR_IDLE;
      airborne_q   <= 1'b0;
      on_ground_q  <= 1'b1;
      ducking_q    <= 1'b0;
      dead_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      jump_q       <= jump;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      sprite_sel_q <= sprite_for(state_d, phase_d);
      airborne_q   <= (state_d == AIR);
      on_ground_q  <= (state_d == IDLE) || (state_d == RUN) || (state_d == DUCK);
      ducking_q    <= (state_d == DUCK);
      dead_q       <= (state_d == DEAD);
    end
  end

  dino_vert_integrator #(
    .Y_W      (Y_W),
    .GROUND_Y (GROUND_Y),
    .JUMP_V0  (JUMP_V0),
    .GRAVITY  (GRAVITY)
  ) u_vert (
    .AnimateClk  (AnimateClk),
    .rst         (rst),
    .launch_i    (launch),
    .fly_i       (fly),
    .freeze_i    (freeze),
    .fast_drop_i (fast_drop),
    .y_o         (dino_y),
    .landed_o    (landed)
  );

  assign sprite_sel = sprite_sel_q;
  assign airborne   = airborne_q;
  assign on_ground  = on_ground_q;
  assign ducking    = ducking_q;
  assign dead       = dead_q;

endmodule
